cruce_vehicular_param: RTL and testbench

- Parametrised N-approach intersection controller. Successor to the fixed two-approach pedestrian-light block.
- Generates the vehicle light for each approach (2-bit code: 2'b10 green, 2'b01 yellow, 2'b00 red) and a pedestrian light for each approach.
- Adds internal phase timers, per-approach demand sensors with round-robin skipping, and an all-red clearance interval.
- Sits at the top of the Cruce_Vehicular design. Driven by the common clk/reset/enb tester.

---
 rtl/cruce_vehicular_param.sv | 164 ++++++++++++++++
 tb/tb_cruce_vehicular_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cruce_vehicular_param.sv
// cruce_vehicular_param: N-approach intersection controller with demand
// sensors, round-robin skipping of idle approaches and an all-red clearance.
// Optional night flashing mode: define CRUCE_INTERMITENTE_EN (adds modo_noche).
// Lights are registered decodes of the next state, so the vehicle and
// pedestrian lights change on the same edge as the phase.

module cruce_via_luz (
  input  logic       es_verde,
  input  logic       es_amarillo,
  input  logic       es_noche,
  input  logic       sel,
  input  logic       flash,
  output logic [1:0] luz,
  output logic       peaton
);
  // Light and crossing of one approach, decoded from the next state
  always_comb begin
    luz = 2'b00;
    if (sel && es_verde)         luz = 2'b10;
    else if (sel && es_amarillo) luz = 2'b01;
    else if (es_noche && flash)  luz = 2'b01;
    peaton = es_verde && !sel;
  end
endmodule

module cruce_vehicular_param #(
  parameter int NUM_VIAS     = 2,
  parameter int T_VERDE      = 8,
  parameter int T_AMARILLO   = 3,
  parameter int T_TODOS_ROJO = 2,
  parameter int T_FLASH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enb,
  input  logic [NUM_VIAS-1:0]           sensor,
`ifdef CRUCE_INTERMITENTE_EN
  input  logic                          modo_noche,
`endif
  output logic [2*NUM_VIAS-1:0]         semaforo,
  output logic [NUM_VIAS-1:0]           peatonal,
  output logic [$clog2(NUM_VIAS)-1:0]   via_activa
);
  localparam int VW    = $clog2(NUM_VIAS);
  localparam int T_VA  = (T_VERDE > T_AMARILLO) ? T_VERDE : T_AMARILLO;
  localparam int T_RF  = (T_TODOS_ROJO > T_FLASH) ? T_TODOS_ROJO : T_FLASH;
  localparam int T_MAX = (T_VA > T_RF) ? T_VA : T_RF;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam logic [2*NUM_VIAS-1:0] SEM_RST = (2*NUM_VIAS)'(2'b10);

  typedef enum logic [1:0] {
    VERDE      = 2'd0,
    AMARILLO   = 2'd1,
    TODOS_ROJO = 2'd2,
    NOCHE      = 2'd3
  } estado_e;

  estado_e               state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [VW-1:0]         via_q, via_d, via_sig;
  logic                  flash_q, flash_d;
  logic [2*NUM_VIAS-1:0] semaforo_q, semaforo_d;
  logic [NUM_VIAS-1:0]   peatonal_q, peatonal_d;
  logic [NUM_VIAS-1:0]   sel_oh;
  logic [2*NUM_VIAS-1:0] rot;
  logic                  demanda_otra;
  logic                  es_verde, es_amarillo, es_noche;

  // State register; reset wins over enb, enb=0 freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= VERDE;
      cnt_q      <= '0;
      via_q      <= '0;
      flash_q    <= 1'b0;
      semaforo_q <= SEM_RST;
      peatonal_q <= '0;
    end else if (enb) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      via_q      <= via_d;
      flash_q    <= flash_d;
      semaforo_q <= semaforo_d;
      peatonal_q <= peatonal_d;
    end
  end

  // Next green: first demanding approach after the current one, else k+1
  always_comb begin
    rot     = {sensor, sensor} >> via_q;
    via_sig = VW'((int'(via_q) + 1) % NUM_VIAS);
    for (int off = NUM_VIAS - 1; off >= 1; off--)
      if (rot[off]) via_sig = VW'((int'(via_q) + off) % NUM_VIAS);
  end

  assign demanda_otra = |(sensor & ~sel_oh);

  // Next-state: phase timing, green extension and night override
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    via_d   = via_q;
    flash_d = flash_q;
    case (state_q)
      VERDE: if (cnt_q == CW'(T_VERDE - 1)) begin
        cnt_d = '0;
        if (demanda_otra) state_d = AMARILLO;
      end
      AMARILLO: if (cnt_q == CW'(T_AMARILLO - 1)) begin
        state_d = TODOS_ROJO;
        cnt_d   = '0;
      end
      TODOS_ROJO: if (cnt_q == CW'(T_TODOS_ROJO - 1)) begin
        state_d = VERDE;
        cnt_d   = '0;
        via_d   = via_sig;
      end
`ifdef CRUCE_INTERMITENTE_EN
      NOCHE: if (!modo_noche) begin
        state_d = TODOS_ROJO;
        cnt_d   = '0;
      end else if (cnt_q == CW'(T_FLASH - 1)) begin
        cnt_d   = '0;
        flash_d = ~flash_q;
      end
`endif
      default: begin
        state_d = VERDE;
        cnt_d   = '0;
      end
    endcase
`ifdef CRUCE_INTERMITENTE_EN
    if (modo_noche && state_q != NOCHE) begin
      state_d = NOCHE;
      cnt_d   = '0;
      flash_d = 1'b1;
    end
`endif
  end

  // Output decode of the next state feeding the light registers
  always_comb begin
    es_verde    = (state_d == VERDE);
    es_amarillo = (state_d == AMARILLO);
    es_noche    = (state_d == NOCHE);
  end

  for (genvar i = 0; i < NUM_VIAS; i++) begin : g_via
    assign sel_oh[i] = (via_q == VW'(i));
    cruce_via_luz u_luz (
      .es_verde    (es_verde),
      .es_amarillo (es_amarillo),
      .es_noche    (es_noche),
      .sel         (via_d == VW'(i)),
      .flash       (flash_d),
      .luz         (semaforo_d[2*i +: 2]),
      .peaton      (peatonal_d[i])
    );
  end

  assign semaforo   = semaforo_q;
  assign peatonal   = peatonal_q;
  assign via_activa = via_q;
endmodule

// File: tb/tb_cruce_vehicular_param.sv
// Bench for cruce_vehicular_param: a 2-approach and a 4-approach instance run
// side by side against a phase/time-left model, plus literal expectations.
module tb_cruce_vehicular_param;
  localparam int TV = 4, TY = 2, TR = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2, enb2;
  logic [1:0] sens2, ped2;
  logic [3:0] sem2;
  logic       via2;
  logic       rst4, enb4;
  logic [3:0] sens4, ped4;
  logic [7:0] sem4;
  logic [1:0] via4;

  int n_chk = 0;
  int n_pass = 0;

  cruce_vehicular_param #(.NUM_VIAS(2), .T_VERDE(TV), .T_AMARILLO(TY), .T_TODOS_ROJO(TR)) dut2 (
    .clk(clk), .reset(rst2), .enb(enb2), .sensor(sens2),
`ifdef CRUCE_INTERMITENTE_EN
    .modo_noche(1'b0),
`endif
    .semaforo(sem2), .peatonal(ped2), .via_activa(via2));

  cruce_vehicular_param #(.NUM_VIAS(4), .T_VERDE(TV), .T_AMARILLO(TY), .T_TODOS_ROJO(TR)) dut4 (
    .clk(clk), .reset(rst4), .enb(enb4), .sensor(sens4),
`ifdef CRUCE_INTERMITENTE_EN
    .modo_noche(1'b0),
`endif
    .semaforo(sem4), .peatonal(ped4), .via_activa(via4));

  // Model: phase (0 green, 1 yellow, 2 all-red), green approach, cycles left
  typedef struct { int ph; int k; int left; bit lag; } mdl_t;
  mdl_t m2 = '{0, 0, 0, 1'b0};
  mdl_t m4 = '{0, 0, 0, 1'b0};

  function automatic mdl_t mstep(mdl_t m, int n, bit rst, bit en, int s);
    mdl_t r = m;
    bit   hit;
    if (rst) begin
      r.ph = 0; r.k = 0; r.left = TV; r.lag = 1'b1;
    end else if (en) begin
      r.lag  = 1'b0;
      r.left = r.left - 1;
      if (r.left == 0) begin
        if (r.ph == 0) begin
          hit = 1'b0;
          for (int j = 0; j < n; j++)
            if (j != r.k && ((s >> j) & 1) == 1) hit = 1'b1;
          if (hit) begin r.ph = 1; r.left = TY; end
          else r.left = TV;
        end else if (r.ph == 1) begin
          r.ph = 2; r.left = TR;
        end else begin
          hit = 1'b0;
          for (int d = 1; d < n; d++)
            if (!hit && ((s >> ((m.k + d) % n)) & 1) == 1) begin
              hit = 1'b1; r.k = (m.k + d) % n;
            end
          if (!hit) r.k = (m.k + 1) % n;
          r.ph = 0; r.left = TV;
        end
      end
    end
    return r;
  endfunction

  function automatic int msem(mdl_t m);
    if (m.ph == 0) return 2 << (2 * m.k);
    if (m.ph == 1) return 1 << (2 * m.k);
    return 0;
  endfunction

  function automatic int mped(mdl_t m, int n);
    if (m.ph == 0 && !m.lag) return ((1 << n) - 1) & ~(1 << m.k);
    return 0;
  endfunction

  function automatic int pack(int s, int p, int v);
    return (s << 16) | (p << 8) | v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %h want %h (sem<<16|ped<<8|via)", nm, act, exp);
  endtask

  task automatic lit2(string nm, int s, int p, int v);
    chk(nm, pack(int'(sem2), int'(ped2), int'(via2)), pack(s, p, v));
    chk({nm, "_model"}, pack(msem(m2), mped(m2, 2), m2.k), pack(s, p, v));
  endtask

  task automatic lit4(string nm, int s, int p, int v);
    chk(nm, pack(int'(sem4), int'(ped4), int'(via4)), pack(s, p, v));
    chk({nm, "_model"}, pack(msem(m4), mped(m4, 4), m4.k), pack(s, p, v));
  endtask

  task automatic nx(int k);
    repeat (k) @(negedge clk);
  endtask

  always @(posedge clk) begin
    m2 = mstep(m2, 2, rst2, enb2, int'(sens2));
    m4 = mstep(m4, 4, rst4, enb4, int'(sens4));
  end

  // Every cycle, both instances against the model
  always @(negedge clk) begin
    chk("cyc_n2", pack(int'(sem2), int'(ped2), int'(via2)), pack(msem(m2), mped(m2, 2), m2.k));
    chk("cyc_n4", pack(int'(sem4), int'(ped4), int'(via4)), pack(msem(m4), mped(m4, 4), m4.k));
  end

  initial begin
    rst2 = 1'b1; enb2 = 1'b1; sens2 = 2'b11;
    rst4 = 1'b1; enb4 = 1'b1; sens4 = 4'b1001;

    // Test 1: basic cycle, pedestrian lag after reset
    nx(1); lit2("t1_e0", 'b0010, 0, 0); rst2 = 1'b0;
    nx(1); lit2("t1_e1", 'b0010, 'b10, 0);
    nx(2); lit2("t1_e3", 'b0010, 'b10, 0);
    nx(1); lit2("t1_e4", 'b0001, 0, 0);
    nx(1); lit2("t1_e5", 'b0001, 0, 0);
    nx(1); lit2("t1_e6", 0, 0, 0);
    nx(1); lit2("t1_e7", 'b1000, 'b01, 1);

    // Test 2: no other demand extends green; demand yellows at the boundary
    rst2 = 1'b1; sens2 = 2'b01;
    nx(1); lit2("t2_rst", 'b0010, 0, 0); rst2 = 1'b0;
    nx(9); lit2("t2_extend", 'b0010, 'b10, 0); sens2 = 2'b11;
    nx(2); lit2("t2_last_green", 'b0010, 'b10, 0);
    nx(1); lit2("t2_yellow", 'b0001, 0, 0);

    // Test 3: enb low for 5 edges freezes the phase
    rst2 = 1'b1;
    nx(1); rst2 = 1'b0;
    nx(1); lit2("t3_e1", 'b0010, 'b10, 0); enb2 = 1'b0;
    nx(3); lit2("t3_frozen", 'b0010, 'b10, 0);
    nx(2); enb2 = 1'b1;
    nx(2); lit2("t3_e8", 'b0010, 'b10, 0);
    nx(1); lit2("t3_e9", 'b0001, 0, 0);

    // Test 4: reset during yellow and during all-red after approach 1
    rst2 = 1'b1;
    nx(1); rst2 = 1'b0;
    nx(4); lit2("t4_e4", 'b0001, 0, 0);
    nx(1); rst2 = 1'b1;
    nx(1); lit2("t4_rst_yellow", 'b0010, 0, 0); rst2 = 1'b0;
    nx(7); lit2("t4_green1", 'b1000, 'b01, 1);
    nx(6); lit2("t4_allred", 0, 0, 1); rst2 = 1'b1;
    nx(1); lit2("t4_rst_allred", 'b0010, 0, 0); rst2 = 1'b0;
    nx(1); lit2("t4_lag", 'b0010, 'b10, 0);

    // Test 5: four approaches, skipping idle ones
    rst4 = 1'b0;
    nx(6); lit4("t5_allred", 0, 0, 0);
    nx(1); lit4("t5_green3", 'h80, 'b0111, 3);
    nx(4); lit4("t5_yellow3", 'h40, 0, 3); sens4 = 4'b0110;
    nx(2); lit4("t5_allred3", 0, 0, 3);
    nx(1); lit4("t5_green1", 'h08, 'b1101, 1); sens4 = 4'b0000;
    nx(10); lit4("t5_zero_extend", 'h08, 'b1101, 1); sens4 = 4'b0100;
    for (int i = 0; i < 8 && m4.ph != 1; i++) nx(1);
    chk("t5_reach_yellow", m4.ph, 1);
    sens4 = 4'b0000;
    nx(3); lit4("t5_fallback", 'h20, 'b1011, 2);

    nx(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
